// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath -- execute stage of the small accumulator microprocessor.
//
// Owns the architectural data state: accumulator A, register B, carry flag C
// and the output port register. Each instruction executes in a single cycle.
// Decode is combinational from `inst`, and all state updates on the rising
// edge that ends the instruction's cycle. Jump opcodes (JMP/JC) are handled by
// the control logic, so here they only hold state and drop out_strobe.
//
// Ports
//   clk        in   1           sole clock, rising edge
//   rst        in   1           synchronous active-high reset, clears all state
//   inst       in   INST_WIDTH  current instruction word
//   alu_cout   out  1           registered carry flag C (feeds the JC decision)
//   out        out  DATA_WIDTH  output port register, loaded by OUT
//   out_strobe out  1           high for the cycle after each OUT
//   acc        out  DATA_WIDTH  current accumulator value (debug/verification)
// -----------------------------------------------------------------------------
module datapath #(
    parameter int INST_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int DATA_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst,
    output logic                  alu_cout,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_strobe,
    output logic [DATA_WIDTH-1:0] acc
);

    localparam int OPERAND_WIDTH = INST_WIDTH - OPCODE_WIDTH;

    typedef enum logic [1:0] {
        SUBOP_LDI  = 2'b00,
        SUBOP_ADDI = 2'b01,
        SUBOP_ADDB = 2'b10,
        SUBOP_MISC = 2'b11   // operand bit 0 selects MOVB (0) or OUT (1)
    } subop_e;

    // Architectural state
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_c;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_out_strobe;

    // Decode
    logic                  w_is_jump;
    subop_e                w_subop;
    logic                  w_sel_bit;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_is_jump = inst[INST_WIDTH-1] | inst[INST_WIDTH-2];
    assign w_subop   = subop_e'(inst[INST_WIDTH-3 -: 2]);
    assign w_sel_bit = inst[0];

    // Immediate: operand field zero-extended or truncated to DATA_WIDTH.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_imm
            if (gi < OPERAND_WIDTH) begin : g_bit
                assign w_imm[gi] = inst[gi];
            end else begin : g_zero
                assign w_imm[gi] = 1'b0;
            end
        end
    endgenerate

    // One shared adder: ADDB adds B, ADDI adds the immediate. The extra top
    // bit of the sum is the carry-out of bit DATA_WIDTH-1.
    assign w_addend = (w_subop == SUBOP_ADDB) ? r_b : w_imm;
    assign w_sum    = {1'b0, r_a} + {1'b0, w_addend};

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over whatever instruction is on inst this cycle.
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= 1'b0;
            r_out        <= '0;
            r_out_strobe <= 1'b0;
        end else begin
            r_out_strobe <= 1'b0;
            if (!w_is_jump) begin
                case (w_subop)
                    SUBOP_LDI: begin
                        r_a <= w_imm;
                    end
                    SUBOP_ADDI, SUBOP_ADDB: begin
                        r_a <= w_sum[DATA_WIDTH-1:0];
                        r_c <= w_sum[DATA_WIDTH];
                    end
                    SUBOP_MISC: begin
                        if (w_sel_bit) begin
                            r_out        <= r_a;
                            r_out_strobe <= 1'b1;
                        end else begin
                            r_b <= r_a;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // C is returned straight from its flop so the control logic's PC-load
    // path never depends on this cycle's adder.
    assign alu_cout   = r_c;
    assign out        = r_out;
    assign out_strobe = r_out_strobe;
    assign acc        = r_a;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath -- self-checking bench for datapath (default 8/4/4 encoding).
//
// A behavioural model tracks A, B, C, out and out_strobe with plain integer
// arithmetic; a negedge compare process checks every DUT output against it
// each cycle once reset has been applied. A few literal expectations taken
// from hand-worked programs pin the model itself.
// -----------------------------------------------------------------------------
module tb_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] inst;
    logic       alu_cout;
    logic [3:0] out_w;
    logic       out_strobe;
    logic [3:0] acc;

    datapath #(
        .INST_WIDTH   (8),
        .OPCODE_WIDTH (4),
        .DATA_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .alu_cout   (alu_cout),
        .out        (out_w),
        .out_strobe (out_strobe),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model of the architectural state
    int m_a   = 0;
    int m_b   = 0;
    int m_c   = 0;
    int m_out = 0;
    int m_stb = 0;

    task automatic model_exec(input logic [7:0] i, input bit r);
        int s;
        if (r) begin
            m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_stb = 0;
        end else begin
            m_stb = 0;
            if (i[7] == 1'b0 && i[6] == 1'b0) begin
                case (i[5:4])
                    2'd0: m_a = i[3:0];
                    2'd1: begin
                        s   = m_a + i[3:0];
                        m_a = s % 16;
                        m_c = (s >= 16) ? 1 : 0;
                    end
                    2'd2: begin
                        s   = m_a + m_b;
                        m_a = s % 16;
                        m_c = (s >= 16) ? 1 : 0;
                    end
                    default: begin
                        if (i[0]) begin
                            m_out = m_a;
                            m_stb = 1;
                        end else begin
                            m_b = m_a;
                        end
                    end
                endcase
            end
        end
    endtask

    // Apply one instruction for one cycle, then advance the model.
    task automatic step(input logic [7:0] i, input bit r);
        inst = i;
        rst  = r;
        @(posedge clk);
        #1;
        model_exec(i, r);
        chk_en = 1'b1;
    endtask

    task automatic expect_val(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            expect_val("model acc",        int'(acc),        m_a);
            expect_val("model alu_cout",   int'(alu_cout),   m_c);
            expect_val("model out",        int'(out_w),      m_out);
            expect_val("model out_strobe", int'(out_strobe), m_stb);
        end
    end

    initial begin
        inst = 8'h00;
        rst  = 1'b1;

        // Reset held two cycles with an ADDI on inst
        step(8'h1F, 1'b1);
        step(8'h1F, 1'b1);
        expect_val("reset acc",    int'(acc),        0);
        expect_val("reset cout",   int'(alu_cout),   0);
        expect_val("reset out",    int'(out_w),      0);
        expect_val("reset strobe", int'(out_strobe), 0);
        step(8'h00, 1'b0);                 // LDI 0
        $display("LDI 0 after reset: acc=%0d cout=%0d", acc, alu_cout);

        // Carry and wrap
        step(8'h09, 1'b0);                 // LDI 9
        step(8'h18, 1'b0);                 // ADDI 8 -> 17 -> A=1, C=1
        expect_val("wrap acc",  int'(acc),      1);
        expect_val("wrap cout", int'(alu_cout), 1);
        step(8'h10, 1'b0);                 // ADDI 0 -> C cleared
        expect_val("addi0 cout", int'(alu_cout), 0);
        step(8'h07, 1'b0);                 // LDI 7, C holds
        expect_val("ldi7 acc", int'(acc), 7);

        // Register path
        step(8'h05, 1'b0);                 // LDI 5
        step(8'h30, 1'b0);                 // MOVB -> B=5
        step(8'h03, 1'b0);                 // LDI 3
        step(8'h20, 1'b0);                 // ADDB -> 8
        expect_val("addb acc", int'(acc), 8);
        step(8'h20, 1'b0);                 // ADDB -> 13
        expect_val("addb2 acc", int'(acc), 13);
        step(8'h20, 1'b0);                 // ADDB -> 18 -> A=2, C=1
        expect_val("addb3 acc",  int'(acc),      2);
        expect_val("addb3 cout", int'(alu_cout), 1);

        // Jumps are no-ops here
        step(8'h85, 1'b0);                 // JMP 5
        step(8'h43, 1'b0);                 // JC 3
        expect_val("jump acc",  int'(acc),      2);
        expect_val("jump cout", int'(alu_cout), 1);
        $display("after JMP/JC: acc=%0d cout=%0d out=%0d", acc, alu_cout, out_w);

        // Output handshake
        step(8'h08, 1'b0);                 // LDI 8
        step(8'h31, 1'b0);                 // OUT
        expect_val("out1 value",  int'(out_w),      8);
        expect_val("out1 strobe", int'(out_strobe), 1);
        step(8'h07, 1'b0);                 // LDI 7: strobe drops
        expect_val("out1 strobe drop", int'(out_strobe), 0);
        step(8'h08, 1'b0);                 // LDI 8
        step(8'h31, 1'b0);                 // OUT
        step(8'h31, 1'b0);                 // OUT, strobe stays high
        expect_val("out2 strobe", int'(out_strobe), 1);
        step(8'h11, 1'b0);                 // ADDI 1 -> 9, strobe 0
        expect_val("addi1 strobe", int'(out_strobe), 0);
        step(8'h31, 1'b0);                 // OUT -> 9
        expect_val("out3 value",  int'(out_w),      9);
        expect_val("out3 strobe", int'(out_strobe), 1);

        // Reset collisions
        step(8'h0F, 1'b0);                 // LDI 15
        step(8'h11, 1'b1);                 // ADDI 1 under reset
        expect_val("rst add acc",  int'(acc),      0);
        expect_val("rst add cout", int'(alu_cout), 0);
        step(8'h31, 1'b1);                 // OUT under reset
        expect_val("rst out strobe", int'(out_strobe), 0);
        expect_val("rst out value",  int'(out_w),      0);

        // Post-reset execution against zeroed state (B must be 0)
        step(8'h03, 1'b0);                 // LDI 3
        step(8'h20, 1'b0);                 // ADDB -> 3 + 0
        expect_val("post rst addb", int'(acc), 3);
        step(8'h31, 1'b0);                 // OUT
        step(8'h00, 1'b0);

        chk_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Execute stage of the microprocessor: consumes the instruction word driven by the control logic (program counter + instruction ROM) and owns the architectural data state, i.e. accumulator A, register B, carry flag C and an output port. The registered carry flag is returned to the control logic as `alu_cout`, where it qualifies the conditional jump. Jump instructions are decoded by the control logic only; this block treats them as no-ops.

## Interface
- `INST_WIDTH`, 8: instruction word width; must match the control logic.
- `OPCODE_WIDTH`, 4: opcode field width, `inst[INST_WIDTH-1 -: OPCODE_WIDTH]`; must be ≥ 4.
- `DATA_WIDTH`, 4: width of A, B and `out`.

- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `inst`  input  INST_WIDTH  current instruction, combinationally valid for the whole cycle.
- `alu_cout`  output  1  registered carry flag C.
- `out`  output  DATA_WIDTH  output register, loaded by OUT.
- `out_strobe`  output  1  high for exactly the cycle after each OUT executes.
- `acc`  output  DATA_WIDTH  current value of A, for debug and verification.

## Operation
- Opcode bit `inst[INST_WIDTH-1]` = JMP; `inst[INST_WIDTH-2]` = JC. If either is set, A, B, C and `out` hold, and `out_strobe` goes to 0.
- Otherwise the sub-op is `inst[INST_WIDTH-3:INST_WIDTH-4]`. Remaining opcode bits, if any, are ignored.
- Immediate `imm`: the operand field `inst[INST_WIDTH-OPCODE_WIDTH-1:0]`, zero-extended or truncated to DATA_WIDTH.
- Sub-op 00, LDI: A ← imm. C holds.
- Sub-op 01, ADDI: {C, A} ← A + imm, computed at DATA_WIDTH+1 bits. C is the carry-out of bit DATA_WIDTH-1.
- Sub-op 10, ADDB: {C, A} ← A + B, with the same width rule.
- Sub-op 11 with operand bit 0 = 0, MOVB: B ← A. C holds.
- Sub-op 11 with operand bit 0 = 1, OUT: `out` ← A, and `out_strobe` ← 1 for the next cycle.
- Other operand bits of ADDB and the 11 group are ignored.
- C changes only on ADDI and ADDB. JC does not consume or clear C.
- Arithmetic wraps modulo 2^DATA_WIDTH, with overflow reported only through C.
- Default encoding (8/4/4): LDI n = 0x0n, ADDI n = 0x1n, ADDB = 0x20, MOVB = 0x30, OUT = 0x31, JC n = 0x4n, JMP n = 0x8n.

## Timing
- Single cycle per instruction. Decode is combinational from `inst`; A, B, C, `out` and `out_strobe` update on the rising edge that ends the instruction's cycle.
- `alu_cout` is a flop output. A JC in cycle n sees the carry from the last ADD executed in cycle n-1 or earlier. It never sees a combinational carry from the current cycle, which keeps `alu_cout` off the PC-load combinational path.
- `out_strobe` stays high in each cycle that follows an OUT. Back-to-back OUTs give a continuous high level, with `out` updating every cycle.
- Reset: when `rst` = 1 at a rising edge, A, B, C, `out` and `out_strobe` all become 0, regardless of `inst`. Reset has priority over any instruction executing in the same cycle, including ADD and OUT.
- Reset mid-program: this block and the control logic share `rst`. The first post-reset instruction is ROM address 0 and executes against zeroed state.
- No X propagation: every state element is written with a defined value on reset.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `inst` = 0x1F → A = B = C = `out` = 0 and `out_strobe` = 0. Release `rst`, apply LDI 0 → state unchanged.
- Carry and wrap: LDI 9 (0x09), then ADDI 8 (0x18) → A = 1 and `alu_cout` = 1 from the next cycle. Then ADDI 0 (0x10) → A = 1, C = 0. Then LDI 7 → C still 0.
- Register path: LDI 5, MOVB (0x30), LDI 3, ADDB (0x20) → B = 5, A = 8, C = 0. Then ADDB twice → A = 13, C = 0, then A = 2, C = 1.
- Output handshake: with A = 8, apply OUT (0x31) → `out` = 8, `out_strobe` high for exactly 1 cycle. Then OUT, ADDI 1, OUT → `out_strobe` pattern 1,1 then 0 then 1 (one cycle lagging each instruction); `out` = 8, then 9.
- Jumps are no-ops: with A = 2, B = 5, C = 1, apply JMP 0x85, then JC 0x43 → A, B, C and `out` unchanged, `out_strobe` = 0, `alu_cout` stays 1.
- Reset collision: LDI 15, then ADDI 1 with `rst` = 1 in the same cycle → A = 0 and C = 0, not A = 0 with C = 1. Then OUT with `rst` = 1 → `out_strobe` stays 0.
